// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM row controller.
// State set grows by one capture state when SRAM_CTRL_WRITE_VERIFY_EN is defined.
package sram_ctrl_pkg;

   localparam int unsigned DEF_ROW_AW    = 3;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_PRE_CYC   = 1;
   localparam int unsigned DEF_PULSE_CYC = 2;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StWlOn,
      StPulse,
      StCapt,
      StDone
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
      , StVrfy
`endif
   } state_e;

   // Down-counter width able to hold max(pre, pulse) - 1, never zero bits wide.
   function automatic int unsigned cnt_width(input int unsigned pre, input int unsigned pulse);
      int unsigned m;
      m = (pre > pulse) ? pre : pulse;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sram_row_decode.sv
// Registered binary-to-one-hot word-line decoder; all lines low when en is low.
module sram_row_decode #(
   parameter int unsigned ROW_AW = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [ROW_AW-1:0]      addr,
   output logic [2**ROW_AW-1:0]   wl
);

   logic [2**ROW_AW-1:0] wl_d;

   always_comb begin
      wl_d = '0;
      if (en) wl_d[addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wl <= '0;
      else        wl <= wl_d;
   end

endmodule

// File: rtl/sram_row_ctrl.sv
// Read/write sequencer for one SRAM column bank: precharge, word line, strobe, capture.
// Define SRAM_CTRL_WRITE_VERIFY_EN to follow each write with a read-back compare.
module sram_row_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ROW_AW    = DEF_ROW_AW,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned PRE_CYC   = DEF_PRE_CYC,
   parameter int unsigned PULSE_CYC = DEF_PULSE_CYC
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ROW_AW-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  wr_err,
   output logic [2**ROW_AW-1:0]  wl,
   output logic [DATA_W-1:0]     bl1_drv,
   output logic [DATA_W-1:0]     bl2_drv,
   output logic                  precharge,
   output logic                  read_pulse,
   output logic                  write_pulse,
   input  logic [DATA_W-1:0]     bl1_sense,
   input  logic [DATA_W-1:0]     bl2_sense
);

   localparam int unsigned CNT_W = cnt_width(PRE_CYC, PULSE_CYC);
   localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q;
   logic [ROW_AW-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_d;
   logic                wl_en;
   logic                strobe;
   logic                drive;

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
   // High during the read-back pass that follows a write.
   logic vpass_q, vpass_d;
`else
   logic vpass_d;
   assign vpass_d = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rsp_rdata;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
      vpass_d = vpass_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = StPre;
               cnt_d   = PRE_LOAD;
               err_d   = 1'b0;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
               vpass_d = 1'b0;
`endif
            end
         end
         StPre: begin
            if (cnt_q == '0) state_d = StWlOn;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StWlOn: begin
            state_d = StPulse;
            cnt_d   = PULSE_LOAD;
         end
         StPulse: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StCapt;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
               if (vpass_q) begin
                  state_d = StVrfy;
                  if (bl1_sense == wdata_q) err_d = 1'b0;
                  else                      err_d = 1'b1;
               end
`endif
               // Bit lines must be complementary; unknown bits fall to the error branch.
               if (!we_q) begin
                  rdata_d = bl1_sense;
                  if ((bl1_sense ^ bl2_sense) == {DATA_W{1'b1}}) err_d = 1'b0;
                  else                                           err_d = 1'b1;
               end
            end
         end
         StCapt: begin
            state_d = StDone;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            if (we_q && !vpass_q) begin
               state_d = StPre;
               cnt_d   = PRE_LOAD;
               vpass_d = 1'b1;
            end
`endif
         end
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
         StVrfy: state_d = StDone;
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_comb begin
      wl_en = 1'b0;
      unique case (state_d)
         StWlOn, StPulse, StCapt: wl_en = 1'b1;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
         StVrfy:                  wl_en = 1'b1;
`endif
         default:                 wl_en = 1'b0;
      endcase
      strobe = (state_d == StPulse);
      drive  = wl_en && we_q && !vpass_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         wr_err      <= 1'b0;
         precharge   <= 1'b0;
         read_pulse  <= 1'b0;
         write_pulse <= 1'b0;
         bl1_drv     <= '0;
         bl2_drv     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         if (req_valid && req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         req_ready   <= (state_d == StIdle);
         rsp_valid   <= (state_q == StDone);
         wr_err      <= (state_q == StDone) && err_q;
         rsp_rdata   <= rdata_d;
         precharge   <= (state_d == StPre);
         read_pulse  <= strobe && (!we_q || vpass_d);
         write_pulse <= strobe && we_q && !vpass_d;
         bl1_drv     <= drive ? wdata_q : '0;
         bl2_drv     <= drive ? ~wdata_q : '0;
      end
   end

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vpass_q <= 1'b0;
      else        vpass_q <= vpass_d;
   end
`endif

   sram_row_decode #(
      .ROW_AW (ROW_AW)
   ) u_decode (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wl_en),
      .addr  (addr_q),
      .wl    (wl)
   );

endmodule

// File: tb/tb_sram_row_ctrl.sv
// Directed bench for sram_row_ctrl with a small cell-array model on the bit lines.
// Covers the verify pass when SRAM_CTRL_WRITE_VERIFY_EN is defined.
module tb_sram_row_ctrl;

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
   localparam bit VFY = 1'b1;
`else
   localparam bit VFY = 1'b0;
`endif

   logic       clk, rst_n;
   logic       req_valid, req_ready, req_we;
   logic [2:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid, wr_err;
   logic [7:0] rsp_rdata;
   logic [7:0] wl, bl1_drv, bl2_drv, bl1_sense, bl2_sense;
   logic       precharge, read_pulse, write_pulse;

   logic [7:0] mem [8];
   logic [7:0] mem_rd;
   int         rd_row;
   logic       force_en;
   logic [7:0] force1, force2;
   int         n_vec, n_err, viol;

   sram_row_ctrl u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .wr_err      (wr_err),
      .wl          (wl),
      .bl1_drv     (bl1_drv),
      .bl2_drv     (bl2_drv),
      .precharge   (precharge),
      .read_pulse  (read_pulse),
      .write_pulse (write_pulse),
      .bl1_sense   (bl1_sense),
      .bl2_sense   (bl2_sense)
   );

   always #5 clk = ~clk;

   function automatic int row_of(input logic [7:0] w);
      for (int i = 0; i < 8; i++) if (w[i]) return i;
      return -1;
   endfunction

   always_comb begin
      rd_row    = row_of(wl);
      mem_rd    = (rd_row >= 0) ? mem[rd_row[2:0]] : 8'h00;
      bl1_sense = force_en ? force1 : mem_rd;
      bl2_sense = force_en ? force2 : ~mem_rd;
   end

   always @(posedge clk) begin
      if (write_pulse && row_of(wl) >= 0) mem[row_of(wl)] <= bl1_drv;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (precharge && wl != 8'h00)   viol++;
         if (read_pulse && write_pulse)  viol++;
         if ($countones(wl) > 1)         viol++;
      end
   end

   wire [29:0] obs = {req_ready, rsp_valid, wr_err, precharge, read_pulse, write_pulse,
                      wl, bl1_drv, bl2_drv};

   function automatic int lat(input bit we);
      return (we && VFY) ? 11 : 6;
   endfunction

   // Expected output bus k negedges after the accepting clock edge.
   function automatic logic [29:0] exp_bus(input int k, input bit we, input logic [2:0] a,
                                           input logic [7:0] wd, input bit err);
      int L, j;
      bit p2, in_op, pre, wlon, strobe, drv;
      logic [7:0] wlv;
      L      = lat(we);
      p2     = (k > 5) && (k < L);
      j      = p2 ? k - 5 : k;
      in_op  = (k >= 1) && (k < L);
      pre    = in_op && (j == 1);
      wlon   = in_op && (j >= 2) && (j <= 5);
      strobe = in_op && (j == 3 || j == 4);
      drv    = wlon && we && !p2;
      wlv    = wlon ? (8'h01 << a) : 8'h00;
      return {(k >= L + 1), (k == L + 1), (k == L + 1) && err, pre,
              strobe && (!we || p2), strobe && we && !p2, wlv,
              drv ? wd : 8'h00, drv ? ~wd : 8'h00};
   endfunction

   task automatic issue(input bit we, input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      n_vec++;
      if (obs !== {1'b1, 29'h0} || rsp_rdata !== 8'h00) begin
         n_err++;
         $display("FAIL reset_hold got %h/%h exp %h/00", obs, rsp_rdata, {1'b1, 29'h0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (obs !== {1'b1, 29'h0}) begin
         n_err++;
         $display("FAIL reset_release got %h exp %h", obs, {1'b1, 29'h0});
      end
   endtask

   task automatic test_write_read;
      logic [29:0] e;
      issue(1'b1, 3'd3, 8'hA5);
      for (int k = 1; k <= lat(1'b1) + 1; k++) begin
         @(negedge clk);
         e = exp_bus(k, 1'b1, 3'd3, 8'hA5, 1'b0);
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL write_row3 k=%0d got %h exp %h", k, obs, e);
         end
      end
      issue(1'b0, 3'd3, 8'h00);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         e = exp_bus(k, 1'b0, 3'd3, 8'h00, 1'b0);
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL read_row3 k=%0d got %h exp %h", k, obs, e);
         end
         if (k == 4 || k == 7) begin
            n_vec++;
            if (rsp_rdata !== ((k == 4) ? 8'h00 : 8'hA5)) begin
               n_err++;
               $display("FAIL read_row3_data k=%0d got %h exp %h", k, rsp_rdata,
                        (k == 4) ? 8'h00 : 8'hA5);
            end
         end
      end
   endtask

   task automatic test_rows;
      bit         t_we [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0] t_a  [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
      logic [7:0] t_d  [4] = '{8'h3C, 8'hC3, 8'h3C, 8'hC3};
      logic [29:0] e;
      for (int i = 0; i < 4; i++) begin
         issue(t_we[i], t_a[i], t_we[i] ? t_d[i] : 8'h00);
         for (int k = 1; k <= lat(t_we[i]) + 1; k++) begin
            @(negedge clk);
            e = exp_bus(k, t_we[i], t_a[i], t_we[i] ? t_d[i] : 8'h00, 1'b0);
            n_vec++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL rows op=%0d k=%0d got %h exp %h", i, k, obs, e);
            end
         end
         if (!t_we[i]) begin
            n_vec++;
            if (rsp_rdata !== t_d[i]) begin
               n_err++;
               $display("FAIL rows_data row=%0d got %h exp %h", t_a[i], rsp_rdata, t_d[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int  rsp_cnt;
      logic [1:0] e;
      rsp_cnt = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 3'd3;
      req_wdata = 8'h00;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 1) req_addr = 3'd0;
         if (rsp_valid) rsp_cnt++;
         e = {(k == 7 || k >= 14), (k == 7 || k == 14)};
         n_vec++;
         if ({req_ready, rsp_valid} !== e) begin
            n_err++;
            $display("FAIL b2b_handshake k=%0d got %b exp %b", k, {req_ready, rsp_valid}, e);
         end
         if (k == 7 || k == 14) begin
            n_vec++;
            if (rsp_rdata !== ((k == 7) ? 8'hA5 : 8'h3C)) begin
               n_err++;
               $display("FAIL b2b_data k=%0d got %h exp %h", k, rsp_rdata,
                        (k == 7) ? 8'hA5 : 8'h3C);
            end
         end
         if (k == 8) req_valid = 1'b0;
      end
      n_vec++;
      if (rsp_cnt != 2) begin
         n_err++;
         $display("FAIL b2b_rsp_count got %0d exp 2", rsp_cnt);
      end
   endtask

   task automatic test_reset_mid;
      issue(1'b0, 3'd7, 8'h00);
      repeat (3) @(negedge clk);
      n_vec++;
      if (read_pulse !== 1'b1 || wl !== 8'h80) begin
         n_err++;
         $display("FAIL midrst_pre got rp=%b wl=%h exp rp=1 wl=80", read_pulse, wl);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs !== {1'b1, 29'h0} || rsp_rdata !== 8'h00) begin
         n_err++;
         $display("FAIL midrst_async got %h/%h exp %h/00", obs, rsp_rdata, {1'b1, 29'h0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_vec++;
         if (obs !== {1'b1, 29'h0}) begin
            n_err++;
            $display("FAIL midrst_after k=%0d got %h exp %h", k, obs, {1'b1, 29'h0});
         end
      end
   endtask

   task automatic test_integrity;
      logic [7:0] t1 [3] = '{8'h5A, 8'hF0, 8'hFF};
      logic [7:0] t2 [3] = '{8'h5A, 8'h0F, 8'h01};
      bit         te [3] = '{1'b1, 1'b0, 1'b1};
      logic [29:0] e;
      force_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         force1 = t1[i];
         force2 = t2[i];
         issue(1'b0, 3'd2, 8'h00);
         for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            e = exp_bus(k, 1'b0, 3'd2, 8'h00, te[i]);
            n_vec++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL integrity v=%0d k=%0d got %h exp %h", i, k, obs, e);
            end
         end
         n_vec++;
         if (rsp_rdata !== t1[i]) begin
            n_err++;
            $display("FAIL integrity_data v=%0d got %h exp %h", i, rsp_rdata, t1[i]);
         end
      end
      force_en = 1'b0;
   endtask

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
   task automatic test_verify;
      logic [29:0] e;
      force_en = 1'b1;
      force1   = 8'h3D;
      force2   = 8'hC2;
      issue(1'b1, 3'd4, 8'h3C);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         e = exp_bus(k, 1'b1, 3'd4, 8'h3C, 1'b1);
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL verify k=%0d got %h exp %h", k, obs, e);
         end
      end
      n_vec++;
      if (rsp_rdata !== 8'hFF) begin
         n_err++;
         $display("FAIL verify_rdata_kept got %h exp ff", rsp_rdata);
      end
      force_en = 1'b0;
   endtask
`endif

   task automatic test_invariants;
      n_vec++;
      if (viol != 0) begin
         n_err++;
         $display("FAIL invariants got %0d violations exp 0", viol);
      end
   endtask

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 3'd0;
      req_wdata = 8'h00;
      force_en  = 1'b0;
      force1    = 8'h00;
      force2    = 8'h00;
      n_vec     = 0;
      n_err     = 0;
      viol      = 0;
      test_reset();
      test_write_read();
      test_rows();
      test_back_to_back();
      test_reset_mid();
      test_integrity();
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
      test_verify();
`endif
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
